controlador_matriz: RTL and testbench
=====================================

CONTROLADOR_MATRIZ -- requirements
Module: controlador_matriz

Interface
REQ-001 Parameter N_ELEM, default 25, number of matrix elements processed per operation (5x5).
REQ-002 Parameter ADDR_W, default 5, address width of operand and result memories.
REQ-003 Parameter TIMEOUT, default 15, maximum cycles waited for alu_done per element.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 iniciar  input  1  start request, sampled in IDLE only.
REQ-007 sel_operacao  input  2  operation code: 00 soma, 01 subtracao, 10 oposta, 11 invalid.
REQ-008 rd_addr  output  ADDR_W  read address to operand memories A and B.
REQ-009 rd_data_a, rd_data_b  input  16 each  signed operands, valid one cycle after rd_addr.
REQ-010 alu_start, alu_sel, alu_a, alu_b  output  1/2/16/16  drive to the downstream ALU.
REQ-011 alu_resultado, alu_done  input  16/1  ALU result and completion pulse.
REQ-012 wr_en, wr_addr, wr_data  output  1/ADDR_W/16  result-memory write port.
REQ-013 ocupado, concluido, overflow, erro  output  1 each  busy level, done pulse, sticky overflow, sticky error.

Function
REQ-014 States: IDLE, LER, CAPT, DISP, ESPERA, ESCR, FIM.
REQ-015 IDLE: iniciar=1 with sel_operacao!=11 latches sel into alu_sel, clears idx, overflow and erro, and moves to LER.
REQ-016 IDLE: iniciar=1 with sel_operacao=11 sets erro=1 and stays in IDLE; no memory or ALU activity.
REQ-017 LER: rd_addr=idx; next state CAPT.
REQ-018 CAPT: registers rd_data_a into alu_a and rd_data_b into alu_b; next state DISP.
REQ-019 DISP: alu_start=1 for exactly one cycle; clears the timeout counter; next state ESPERA.
REQ-020 ESPERA: alu_done=1 captures alu_resultado and moves to ESCR; otherwise the counter increments.
REQ-021 ESPERA: if the counter reaches TIMEOUT without alu_done, erro=1, no write, and the next state is IDLE; concluido is not asserted.
REQ-022 ESCR: wr_en=1, wr_addr=idx, wr_data=captured result, all for one cycle.
REQ-023 ESCR: if idx=N_ELEM-1 the next state is FIM; otherwise idx increments and the next state is LER.
REQ-024 FIM: concluido=1 for exactly one cycle; next state IDLE.
REQ-025 With a one-cycle ALU, each element takes 5 cycles, and concluido is asserted 5*N_ELEM+1 cycles after the edge that sampled iniciar.
REQ-026 ocupado=0 in IDLE only and 1 in all other states.
REQ-027 iniciar is ignored outside IDLE.
REQ-028 sel_operacao changes during a run have no effect; alu_sel holds the latched value.
REQ-029 Overflow is set in ESCR and remains set until the next accepted start.
REQ-030 Overflow for soma: alu_a[15]=alu_b[15] and result[15]!=alu_a[15].
REQ-031 Overflow for subtracao: alu_a[15]!=alu_b[15] and result[15]!=alu_a[15].
REQ-032 Overflow for oposta: alu_a=-32768.
REQ-033 Overflow does not stop the run; the wrapped 16-bit result is still written.
REQ-034 alu_done received outside ESPERA is ignored.

Reset
REQ-035 reset=0 forces, asynchronously: state IDLE, idx=0, counter=0, rd_addr=0, alu_start=0, alu_sel=00, alu_a=0, alu_b=0, wr_en=0, wr_addr=0, wr_data=0, ocupado=0, concluido=0, overflow=0, erro=0.
REQ-036 Reset asserted mid-run aborts the run immediately with no further writes.
REQ-037 After reset release, the block waits in IDLE for a new iniciar.

Verification
REQ-038 Soma: A[i]=i, B[i]=100, iniciar with sel=00. Required: 25 writes with wr_data=i+100 at wr_addr=i; concluido at cycle 126; overflow=0.
REQ-039 Overflow on soma: A[3]=32767, B[3]=1, sel=00. Required: wr_data=-32768 at address 3, overflow=1 until the next start, and all 25 writes still complete.
REQ-040 Oposta: A[0]=-32768, A[1]=5, sel=10. Required: address 1 written with -5, address 0 written with -32768, overflow=1.
REQ-041 Timeout: ALU model never asserts alu_done. Required: erro=1 sixteen cycles after the DISP cycle; no wr_en pulse; return to IDLE; concluido stays 0.
REQ-042 Reset mid-run: reset=0 during element 10 ESPERA. Required: all outputs at reset values in the same cycle and no write to address 10; a new iniciar then runs a full 25-element operation.
REQ-043 Invalid operation and busy start: iniciar with sel=11 gives erro=1 and ocupado=0. iniciar pulses during a valid run change neither idx nor the write sequence.

Source files
------------

// File: rtl/controlador_matriz.sv
// Element-wise 5x5 matrix sequencer: reads A/B operands, drives an external ALU,
// writes results back and tracks overflow, timeout and invalid-op errors.
module controlador_matriz #(
  parameter int unsigned N_ELEM  = 25,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [1:0]        sel_operacao,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data_a,
  input  logic [15:0]       rd_data_b,
  output logic              alu_start,
  output logic [1:0]        alu_sel,
  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  input  logic [15:0]       alu_resultado,
  input  logic              alu_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              ocupado,
  output logic              concluido,
  output logic              overflow,
  output logic              erro
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_ELEM - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] OP_SOMA   = 2'b00;
  localparam logic [1:0] OP_SUB    = 2'b01;
  localparam logic [1:0] OP_OPOSTA = 2'b10;
  localparam logic [1:0] OP_INVAL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE, LER, CAPT, DISP, ESPERA, ESCR, FIM
  } state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  idx, idx_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [ADDR_W-1:0]  rd_addr_nxt, wr_addr_nxt;
  logic               alu_start_nxt, wr_en_nxt, ocupado_nxt, concluido_nxt;
  logic               overflow_nxt, erro_nxt;
  logic [1:0]         alu_sel_nxt;
  logic [15:0]        alu_a_nxt, alu_b_nxt, wr_data_nxt;
  logic               ovf;

  // Signed overflow of the result currently presented by the ALU.
  always_comb begin
    ovf = 1'b0;
    case (alu_sel)
      OP_SOMA:   ovf = (alu_a[15] == alu_b[15]) && (alu_resultado[15] != alu_a[15]);
      OP_SUB:    ovf = (alu_a[15] != alu_b[15]) && (alu_resultado[15] != alu_a[15]);
      OP_OPOSTA: ovf = (alu_a == 16'h8000);
      default:   ovf = 1'b0;
    endcase
  end

  // Next state and next registered outputs; outputs reflect the state being entered.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    cnt_nxt       = cnt;
    rd_addr_nxt   = rd_addr;
    alu_sel_nxt   = alu_sel;
    alu_a_nxt     = alu_a;
    alu_b_nxt     = alu_b;
    wr_addr_nxt   = wr_addr;
    wr_data_nxt   = wr_data;
    overflow_nxt  = overflow;
    erro_nxt      = erro;
    alu_start_nxt = 1'b0;
    wr_en_nxt     = 1'b0;
    concluido_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (iniciar) begin
          if (sel_operacao == OP_INVAL) begin
            erro_nxt = 1'b1;
          end else begin
            alu_sel_nxt  = sel_operacao;
            idx_nxt      = '0;
            rd_addr_nxt  = '0;
            overflow_nxt = 1'b0;
            erro_nxt     = 1'b0;
            state_nxt    = LER;
          end
        end
      end
      LER: state_nxt = CAPT;
      CAPT: begin
        alu_a_nxt     = rd_data_a;
        alu_b_nxt     = rd_data_b;
        alu_start_nxt = 1'b1;
        cnt_nxt       = '0;
        state_nxt     = DISP;
      end
      DISP: begin
        cnt_nxt   = '0;
        state_nxt = ESPERA;
      end
      ESPERA: begin
        if (alu_done) begin
          wr_en_nxt    = 1'b1;
          wr_addr_nxt  = idx;
          wr_data_nxt  = alu_resultado;
          overflow_nxt = overflow | ovf;
          state_nxt    = ESCR;
        end else if (cnt == CNT_LAST) begin
          erro_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ESCR: begin
        if (idx == LAST_IDX) begin
          concluido_nxt = 1'b1;
          state_nxt     = FIM;
        end else begin
          idx_nxt     = idx + ADDR_W'(1);
          rd_addr_nxt = idx + ADDR_W'(1);
          state_nxt   = LER;
        end
      end
      FIM:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    ocupado_nxt = (state_nxt != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      rd_addr   <= '0;
      alu_start <= 1'b0;
      alu_sel   <= 2'b00;
      alu_a     <= '0;
      alu_b     <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      ocupado   <= 1'b0;
      concluido <= 1'b0;
      overflow  <= 1'b0;
      erro      <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      rd_addr   <= rd_addr_nxt;
      alu_start <= alu_start_nxt;
      alu_sel   <= alu_sel_nxt;
      alu_a     <= alu_a_nxt;
      alu_b     <= alu_b_nxt;
      wr_en     <= wr_en_nxt;
      wr_addr   <= wr_addr_nxt;
      wr_data   <= wr_data_nxt;
      ocupado   <= ocupado_nxt;
      concluido <= concluido_nxt;
      overflow  <= overflow_nxt;
      erro      <= erro_nxt;
    end
  end

endmodule

// File: tb/tb_controlador_matriz.sv
// Directed bench for controlador_matriz with synchronous operand memories and a
// one-cycle ALU model; expected values are hand-computed per vector.
module tb_controlador_matriz;

  logic        clk = 1'b0;
  logic        reset;
  logic        iniciar;
  logic [1:0]  sel_operacao;
  logic [4:0]  rd_addr;
  logic [15:0] rd_data_a, rd_data_b;
  logic        alu_start;
  logic [1:0]  alu_sel;
  logic [15:0] alu_a, alu_b, alu_resultado;
  logic        alu_done;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        ocupado, concluido, overflow, erro;

  controlador_matriz dut (
    .clk(clk), .reset(reset), .iniciar(iniciar), .sel_operacao(sel_operacao),
    .rd_addr(rd_addr), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .alu_start(alu_start), .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_resultado(alu_resultado), .alu_done(alu_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ocupado(ocupado), .concluido(concluido), .overflow(overflow), .erro(erro)
  );

  always #5 clk = ~clk;

  logic [15:0] mem_a [32];
  logic [15:0] mem_b [32];
  logic        alu_en;

  always @(posedge clk) begin
    rd_data_a <= mem_a[rd_addr];
    rd_data_b <= mem_b[rd_addr];
  end

  always @(posedge clk) begin
    alu_done <= alu_start && alu_en;
    if (alu_start) begin
      case (alu_sel)
        2'b00:   alu_resultado <= alu_a + alu_b;
        2'b01:   alu_resultado <= alu_a - alu_b;
        default: alu_resultado <= 16'h0000 - alu_a;
      endcase
    end
  end

  logic [65:0] outs;
  assign outs = {rd_addr, alu_start, alu_sel, alu_a, alu_b, wr_en, wr_addr, wr_data,
                 ocupado, concluido, overflow, erro};

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  int          done_cyc, err_cyc, start_cyc, n_wr;
  logic        ovf_c1, erro_c1, sel_bad, ocupado_bad, err_ocup;
  logic [65:0] rst_vec;
  logic [4:0]  wa_log [32];
  logic [15:0] wd_log [32];
  logic        ov_log [32];

  // Starts one operation and watches it cycle by cycle; cycle 1 follows the sampling edge.
  task automatic run_op(input logic [1:0] sel, input int busy_cyc, input int rst_cyc,
                        input int limit);
    int cyc;
    @(negedge clk);
    iniciar = 1'b1;
    sel_operacao = sel;
    @(posedge clk);
    cyc = 0; done_cyc = 0; err_cyc = 0; start_cyc = 0; n_wr = 0;
    sel_bad = 1'b0; ocupado_bad = 1'b0; err_ocup = 1'b1; rst_vec = '1;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        iniciar = 1'b0;
        ovf_c1 = overflow;
        erro_c1 = erro;
      end
      if (busy_cyc > 0 && cyc == busy_cyc) begin
        iniciar = 1'b1;
        sel_operacao = 2'b11;
      end
      if (busy_cyc > 0 && cyc == busy_cyc + 3) begin
        iniciar = 1'b0;
        sel_operacao = sel;
      end
      if (rst_cyc > 0 && cyc == rst_cyc) begin
        reset = 1'b0;
        #1 rst_vec = outs;
        break;
      end
      if (alu_start && start_cyc == 0) start_cyc = cyc;
      if (alu_sel !== sel) sel_bad = 1'b1;
      if (wr_en) begin
        if (n_wr < 32) begin
          wa_log[n_wr] = wr_addr;
          wd_log[n_wr] = wr_data;
          ov_log[n_wr] = overflow;
        end
        n_wr++;
      end
      if (concluido) begin
        done_cyc = cyc;
        break;
      end
      if (erro) begin
        err_cyc = cyc;
        err_ocup = ocupado;
        break;
      end
      if (!ocupado) ocupado_bad = 1'b1;
    end
  endtask

  initial begin
    int bad;
    logic seen_c, seen_w;
    iniciar = 1'b0;
    sel_operacao = 2'b00;
    alu_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 16'(i);
      mem_b[i] = 16'd100;
    end
    reset = 1'b1;
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 128'(outs), 128'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_release", {ocupado, wr_en, alu_start}, 3'b000);

    // Soma with busy start pulses (sel=11) injected mid-run
    run_op(2'b00, 40, 0, 400);
    check("soma_done_cycle", done_cyc, 126);
    check("soma_n_writes", n_wr, 25);
    bad = 0;
    for (int i = 0; i < 25; i++)
      if ({wa_log[i], wd_log[i]} !== {5'(i), 16'(i + 100)}) bad++;
    check("soma_write_seq", bad, 0);
    check("soma_w24", {wa_log[24], wd_log[24]}, {5'd24, 16'd124});
    check("soma_overflow", overflow, 1'b0);
    check("soma_erro", erro, 1'b0);
    check("soma_sel_held", sel_bad, 1'b0);
    check("soma_busy_level", ocupado_bad, 1'b0);
    @(negedge clk);
    check("soma_after_fim", {ocupado, concluido}, 2'b00);

    // Invalid operation: error, no activity
    iniciar = 1'b1;
    sel_operacao = 2'b11;
    @(posedge clk);
    @(negedge clk);
    iniciar = 1'b0;
    sel_operacao = 2'b00;
    check("inval_erro_ocupado", {erro, ocupado}, 2'b10);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (ocupado || alu_start || wr_en) bad++;
    end
    check("inval_no_activity", bad, 0);

    // Overflow on soma at element 3
    mem_a[3] = 16'h7FFF;
    mem_b[3] = 16'h0001;
    run_op(2'b00, 0, 0, 400);
    check("ovf_erro_cleared", erro_c1, 1'b0);
    check("ovf_done_cycle", done_cyc, 126);
    check("ovf_n_writes", n_wr, 25);
    check("ovf_w3", {wa_log[3], wd_log[3]}, {5'd3, 16'h8000});
    check("ovf_w4", wd_log[4], 16'd104);
    check("ovf_flag_w2_w3", {ov_log[2], ov_log[3]}, 2'b01);
    check("ovf_sticky_end", overflow, 1'b1);

    // Oposta
    mem_a[0] = 16'h8000;
    mem_a[1] = 16'd5;
    run_op(2'b10, 0, 0, 400);
    check("op_ovf_cleared_at_start", ovf_c1, 1'b0);
    check("op_done_cycle", done_cyc, 126);
    check("op_w0", {wa_log[0], wd_log[0]}, {5'd0, 16'h8000});
    check("op_w1", {wa_log[1], wd_log[1]}, {5'd1, 16'hFFFB});
    check("op_w3", wd_log[3], 16'h8001);
    check("op_ovf_at_w0", ov_log[0], 1'b1);
    check("op_overflow_end", overflow, 1'b1);

    // Subtracao, element 0 wraps (-32768 - 100)
    run_op(2'b01, 0, 0, 400);
    check("sub_ovf_cleared_at_start", ovf_c1, 1'b0);
    check("sub_done_cycle", done_cyc, 126);
    check("sub_w0", wd_log[0], 16'h7F9C);
    check("sub_w1", wd_log[1], 16'hFFA1);
    check("sub_w3", wd_log[3], 16'h7FFE);
    check("sub_ovf_at_w0", ov_log[0], 1'b1);

    // Timeout: ALU never answers
    alu_en = 1'b0;
    run_op(2'b00, 0, 0, 100);
    check("to_disp_cycle", start_cyc, 3);
    check("to_erro_cycle", err_cyc, 19);
    check("to_no_write", n_wr, 0);
    check("to_no_concluido", done_cyc, 0);
    check("to_idle", err_ocup, 1'b0);
    seen_c = 1'b0;
    seen_w = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (concluido) seen_c = 1'b1;
      if (wr_en) seen_w = 1'b1;
    end
    check("to_quiet_after", {seen_c, seen_w, erro}, 3'b001);
    alu_en = 1'b1;

    // Reset during element 10 ESPERA (cycle 54)
    run_op(2'b00, 0, 54, 400);
    check("rst_outputs_async", 128'(rst_vec), 128'd0);
    check("rst_writes_before", n_wr, 10);
    check("rst_last_write", wa_log[9], 5'd9);
    seen_w = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (wr_en || ocupado) seen_w = 1'b1;
    end
    check("rst_no_write_10", seen_w, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_waits_idle", ocupado, 1'b0);
    run_op(2'b00, 0, 0, 400);
    check("rst_rerun_done", done_cyc, 126);
    check("rst_rerun_writes", n_wr, 25);
    check("rst_rerun_w10", {wa_log[10], wd_log[10]}, {5'd10, 16'd110});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
